conv_window_seq: RTL and testbench

Read sequencer for 3x3 convolution windows over the input feature memory of the systolic array. On `start` it latches a frame configuration and walks every valid 3x3 window, output position by output position. For each window it issues single-port SRAM reads for all channels and kernel taps. Returned words are streamed to the array row-input buffers over a ready/valid interface with window framing flags.

---
 rtl/conv_window_seq.sv | 185 ++++++++++++++++++
 tb/tb_conv_window_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_seq.sv
// 3x3 convolution window read sequencer: walks every valid window of a CxHxW frame,
// reads each tap from single-port SRAM and streams it out with window framing flags.
//
// state | meaning
// IDLE  | waiting for start; illegal config pulses err
// RUN   | issuing tap reads whenever output credit allows
// DRAIN | all reads issued, waiting for in-flight read and FIFO to empty
// DONE  | one-cycle done pulse
module conv_window_seq #(
  parameter int ADDR_W   = 16,
  parameter int WORD_LEN = 8,
  parameter int DIM_W    = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start_i,
  input  logic [DIM_W-1:0]    cfg_width_i,
  input  logic [DIM_W-1:0]    cfg_height_i,
  input  logic [DIM_W-1:0]    cfg_channels_i,
  input  logic [ADDR_W-1:0]   cfg_base_i,
  output logic                mem_cen_o,
  output logic [ADDR_W-1:0]   mem_a_o,
  input  logic [WORD_LEN-1:0] mem_q_i,
  output logic [WORD_LEN-1:0] out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                out_first_o,
  output logic                out_last_o,
  output logic                out_frame_last_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q;
  logic [DIM_W-1:0]    w_q, h_q, c_cfg_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DIM_W-1:0]    ox_q, oy_q, ch_q;
  logic [1:0]          kx_q, ky_q;
  logic [DIM_W-1:0]    ox_d, oy_d, ch_d;
  logic [1:0]          kx_d, ky_d;
  logic                rv_q;
  logic [2:0]          rv_flags_q;
  logic [WORD_LEN+2:0] fifo_q [2];
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          count_q;
  logic                err_q;

  logic                ch_last, ox_last, oy_last;
  logic                tap_first, tap_last, tap_frame_last;
  logic                pop, issue, cfg_legal;
  logic [2:0]          occ;
  logic [ADDR_W-1:0]   row, addr;
  logic [WORD_LEN+2:0] head;

  always_comb begin
    ch_last        = (ch_q == c_cfg_q - DIM_W'(1));
    ox_last        = (ox_q == w_q - DIM_W'(3));
    oy_last        = (oy_q == h_q - DIM_W'(3));
    tap_first      = (ch_q == '0) && (ky_q == 2'd0) && (kx_q == 2'd0);
    tap_last       = ch_last && (ky_q == 2'd2) && (kx_q == 2'd2);
    tap_frame_last = tap_last && ox_last && oy_last;
    cfg_legal      = (cfg_width_i >= DIM_W'(3)) && (cfg_height_i >= DIM_W'(3)) &&
                     (cfg_channels_i != '0);
    pop            = (count_q != 2'd0) && out_ready_i;
    // Credit counts the word leaving this cycle, which is what allows 1 word/cycle with 2 entries.
    occ            = {1'b0, count_q} + {2'b00, rv_q} - {2'b00, pop};
    issue          = rstn && (state_q == S_RUN) && (occ < 3'd2);
    row            = ADDR_W'(ch_q) * ADDR_W'(h_q) + ADDR_W'(oy_q) + ADDR_W'(ky_q);
    addr           = base_q + row * ADDR_W'(w_q) + ADDR_W'(ox_q) + ADDR_W'(kx_q);
  end

  always_comb begin
    kx_d = kx_q;
    ky_d = ky_q;
    ch_d = ch_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (kx_q != 2'd2) begin
      kx_d = kx_q + 2'd1;
    end else begin
      kx_d = 2'd0;
      if (ky_q != 2'd2) begin
        ky_d = ky_q + 2'd1;
      end else begin
        ky_d = 2'd0;
        if (!ch_last) begin
          ch_d = ch_q + DIM_W'(1);
        end else begin
          ch_d = '0;
          if (!ox_last) begin
            ox_d = ox_q + DIM_W'(1);
          end else begin
            ox_d = '0;
            oy_d = oy_q + DIM_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      c_cfg_q    <= '0;
      base_q     <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      ch_q       <= '0;
      kx_q       <= '0;
      ky_q       <= '0;
      rv_q       <= 1'b0;
      rv_flags_q <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      // Flags ride alongside the read so they land in the FIFO with their data word.
      rv_q <= issue;
      if (issue) rv_flags_q <= {tap_first, tap_last, tap_frame_last};
      if (rv_q) begin
        fifo_q[wr_ptr_q] <= {rv_flags_q, mem_q_i};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, rv_q} - {1'b0, pop};

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (cfg_legal) begin
              w_q     <= cfg_width_i;
              h_q     <= cfg_height_i;
              c_cfg_q <= cfg_channels_i;
              base_q  <= cfg_base_i;
              ox_q    <= '0;
              oy_q    <= '0;
              ch_q    <= '0;
              kx_q    <= '0;
              ky_q    <= '0;
              state_q <= S_RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            kx_q <= kx_d;
            ky_q <= ky_d;
            ch_q <= ch_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
            if (tap_frame_last) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!rv_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign head             = fifo_q[rd_ptr_q];
  assign mem_cen_o        = ~issue;
  assign mem_a_o          = addr;
  assign out_valid_o      = (count_q != 2'd0);
  assign out_data_o       = out_valid_o ? head[WORD_LEN-1:0] : '0;
  assign out_first_o      = out_valid_o & head[WORD_LEN+2];
  assign out_last_o       = out_valid_o & head[WORD_LEN+1];
  assign out_frame_last_o = out_valid_o & head[WORD_LEN];
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DONE);
  assign err_o            = err_q;

endmodule

// File: tb/tb_conv_window_seq.sv
// Directed bench for conv_window_seq: SRAM model, negedge monitor, per-scenario checks.
module tb_conv_window_seq;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  cfg_w = '0, cfg_h = '0, cfg_c = '0;
  logic [15:0] cfg_base = '0;
  logic        mem_cen;
  logic [15:0] mem_a;
  logic [7:0]  mem_q = '0;
  logic [7:0]  out_data;
  logic        out_valid, out_first, out_last, out_frame_last, busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_window_seq #(.ADDR_W(16), .WORD_LEN(8), .DIM_W(8)) dut (
    .clk(clk), .rstn(rstn), .start_i(start),
    .cfg_width_i(cfg_w), .cfg_height_i(cfg_h), .cfg_channels_i(cfg_c), .cfg_base_i(cfg_base),
    .mem_cen_o(mem_cen), .mem_a_o(mem_a), .mem_q_i(mem_q),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_first_o(out_first), .out_last_o(out_last), .out_frame_last_o(out_frame_last),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]};
  endfunction

  always @(posedge clk) if (!mem_cen) mem_q <= memf(mem_a);

  // Monitor state; only the monitor writes these, the initial block requests a clear via clear_gen.
  int          cyc = 0, clear_gen = 0, seen_gen = 0;
  logic [15:0] rd_q[$];
  int          rd_cyc[$];
  logic [10:0] out_q[$];
  int          hs_cyc[$];
  int          start_cyc, first_valid_cyc, busy_first_cyc, done_cnt, done_cyc;
  int          err_cnt, err_cyc, stab_err, max_out, outstanding;
  bit          busy_seen, done_prev, hold_prev, busy_after_done;
  logic [10:0] hold_word, cur_word;

  always @(negedge clk) begin
    cyc++;
    if (clear_gen != seen_gen) begin
      seen_gen = clear_gen;
      rd_q.delete(); rd_cyc.delete(); out_q.delete(); hs_cyc.delete();
      start_cyc = -1; first_valid_cyc = -1; busy_first_cyc = -1;
      done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
      stab_err = 0; max_out = 0; busy_seen = 0; done_prev = 0; hold_prev = 0;
      busy_after_done = 1;
    end
    cur_word = {out_frame_last, out_last, out_first, out_data};
    if (start && !busy) start_cyc = cyc;
    if (!mem_cen) begin rd_q.push_back(mem_a); rd_cyc.push_back(cyc); end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (busy && busy_first_cyc < 0) busy_first_cyc = cyc;
    if (out_valid && out_ready) begin out_q.push_back(cur_word); hs_cyc.push_back(cyc); end
    if (hold_prev && (out_valid !== 1'b1 || cur_word !== hold_word)) stab_err++;
    hold_prev = out_valid && !out_ready;
    hold_word = cur_word;
    if (done_prev) busy_after_done = busy;
    done_prev = done;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (busy) busy_seen = 1;
    outstanding = rd_q.size() - out_q.size();
    if (outstanding > max_out) max_out = outstanding;
  end

  logic [15:0] exp_addr[$];
  logic [10:0] exp_word[$];

  task automatic build_exp(input int w, input int h, input int c, input logic [15:0] base);
    logic [15:0] a;
    bit f, l, fl;
    exp_addr.delete(); exp_word.delete();
    for (int oy = 0; oy <= h - 3; oy++)
      for (int ox = 0; ox <= w - 3; ox++)
        for (int ch = 0; ch < c; ch++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
              a  = base + 16'((ch * h + oy + ky) * w + ox + kx);
              f  = (ch == 0) && (ky == 0) && (kx == 0);
              l  = (ch == c - 1) && (ky == 2) && (kx == 2);
              fl = l && (oy == h - 3) && (ox == w - 3);
              exp_addr.push_back(a);
              exp_word.push_back({fl, l, f, memf(a)});
            end
  endtask

  // Stimulus only: starts a frame and waits (bounded) for done.
  task automatic run_frame(input int w, input int h, input int c, input logic [15:0] base,
                           input bit rnd, input int mid_at, output bit timed_out);
    clear_gen++;
    cfg_w = 8'(w); cfg_h = 8'(h); cfg_c = 8'(c); cfg_base = base;
    start = 1'b1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_w = 8'd3; cfg_h = 8'd3; cfg_c = 8'd1; cfg_base = 16'h0000;
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      start = (i == mid_at);
      @(posedge clk); #1;
      if (done_cnt != 0) begin timed_out = 1'b0; break; end
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_cen !== 1'b1) begin errors++; $display("FAIL reset_cen got %b want 1", mem_cen); end
    checks++; if (mem_a !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", mem_a); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h0) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
    checks++;
    if ({out_first, out_last, out_frame_last} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {out_first, out_last, out_frame_last});
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_status got %b want 000", {busy, done, err});
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_3x3();
    bit to;
    run_frame(3, 3, 1, 16'h0000, 1'b0, -1, to);
    build_exp(3, 3, 1, 16'h0000);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    checks++; if (rd_q.size() != 9) begin errors++; $display("FAIL basic_reads got %0d want 9", rd_q.size()); end
    checks++; if (out_q.size() != 9) begin errors++; $display("FAIL basic_words got %0d want 9", out_q.size()); end
    for (int i = 0; i < 9 && i < rd_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== exp_addr[i]) begin errors++; $display("FAIL basic_addr[%0d] got %h want %h", i, rd_q[i], exp_addr[i]); end
      checks++;
      if (out_q[i] !== exp_word[i]) begin errors++; $display("FAIL basic_word[%0d] got %h want %h", i, out_q[i], exp_word[i]); end
    end
    checks++; if (out_q[0][8] !== 1'b1) begin errors++; $display("FAIL basic_first got %b want 1", out_q[0][8]); end
    checks++; if (out_q[8][10:9] !== 2'b11) begin errors++; $display("FAIL basic_last got %b want 11", out_q[8][10:9]); end
    checks++; if (busy_first_cyc != start_cyc + 1) begin errors++; $display("FAIL basic_busy_lat got %0d want 1", busy_first_cyc - start_cyc); end
    checks++; if (rd_cyc[0] != start_cyc + 1) begin errors++; $display("FAIL basic_read_lat got %0d want 1", rd_cyc[0] - start_cyc); end
    checks++; if (first_valid_cyc != start_cyc + 3) begin errors++; $display("FAIL basic_valid_lat got %0d want 3", first_valid_cyc - start_cyc); end
    checks++; if (rd_cyc[8] - rd_cyc[0] != 8) begin errors++; $display("FAIL basic_read_span got %0d want 8", rd_cyc[8] - rd_cyc[0]); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
    checks++; if (done_cyc != start_cyc + 12) begin errors++; $display("FAIL basic_done_lat got %0d want 12", done_cyc - start_cyc); end
    checks++; if (busy_after_done !== 1'b0) begin errors++; $display("FAIL basic_busy_drop got %b want 0", busy_after_done); end
  endtask

  task automatic test_multi_channel();
    bit to;
    run_frame(4, 3, 2, 16'h0100, 1'b0, -1, to);
    build_exp(4, 3, 2, 16'h0100);
    checks++; if (to) begin errors++; $display("FAIL multi_timeout got no done want done"); end
    checks++; if (rd_q.size() != 36) begin errors++; $display("FAIL multi_reads got %0d want 36", rd_q.size()); end
    for (int i = 0; i < 36 && i < rd_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== exp_addr[i]) begin errors++; $display("FAIL multi_addr[%0d] got %h want %h", i, rd_q[i], exp_addr[i]); end
      checks++;
      if (out_q[i] !== exp_word[i]) begin errors++; $display("FAIL multi_word[%0d] got %h want %h", i, out_q[i], exp_word[i]); end
    end
    checks++; if (rd_q[9] !== 16'h010C) begin errors++; $display("FAIL multi_ch1_addr got %h want 010c", rd_q[9]); end
    checks++; if (rd_q[18] !== 16'h0101) begin errors++; $display("FAIL multi_win1_start got %h want 0101", rd_q[18]); end
    checks++; if (rd_q[35] !== 16'h0117) begin errors++; $display("FAIL multi_win1_end got %h want 0117", rd_q[35]); end
    checks++; if (out_q[17][10] !== 1'b0) begin errors++; $display("FAIL multi_fl_early got %b want 0", out_q[17][10]); end
    checks++; if (out_q[35][10] !== 1'b1) begin errors++; $display("FAIL multi_fl_final got %b want 1", out_q[35][10]); end
    checks++; if (rd_cyc[35] - rd_cyc[0] != 35) begin errors++; $display("FAIL multi_read_bubbles got %0d want 35", rd_cyc[35] - rd_cyc[0]); end
    checks++; if (hs_cyc[35] - hs_cyc[0] != 35) begin errors++; $display("FAIL multi_out_bubbles got %0d want 35", hs_cyc[35] - hs_cyc[0]); end
    checks++; if (done_cyc != start_cyc + 39) begin errors++; $display("FAIL multi_done_lat got %0d want 39", done_cyc - start_cyc); end
  endtask

  task automatic test_backpressure();
    bit to;
    run_frame(4, 3, 2, 16'h0100, 1'b1, -1, to);
    build_exp(4, 3, 2, 16'h0100);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout got no done want done"); end
    checks++; if (out_q.size() != 36) begin errors++; $display("FAIL bp_words got %0d want 36", out_q.size()); end
    for (int i = 0; i < 36 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_word[i]) begin errors++; $display("FAIL bp_word[%0d] got %h want %h", i, out_q[i], exp_word[i]); end
    end
    checks++; if (max_out != 2) begin errors++; $display("FAIL bp_max_outstanding got %0d want 2", max_out); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_hold_stable got %0d changes want 0", stab_err); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt got %0d want 1", done_cnt); end
    checks++;
    if (done_cyc != hs_cyc[hs_cyc.size() - 1] + 1) begin
      errors++; $display("FAIL bp_done_after_last got %0d want 1", done_cyc - hs_cyc[hs_cyc.size() - 1]);
    end
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 2; k++) begin
      clear_gen++;
      cfg_w = (k == 0) ? 8'd2 : 8'd5;
      cfg_h = 8'd4;
      cfg_c = (k == 0) ? 8'd1 : 8'd0;
      cfg_base = 16'h0200;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (err_cnt != 1) begin errors++; $display("FAIL illegal%0d_err_cnt got %0d want 1", k, err_cnt); end
      checks++; if (err_cyc != start_cyc + 1) begin errors++; $display("FAIL illegal%0d_err_lat got %0d want 1", k, err_cyc - start_cyc); end
      checks++; if (rd_q.size() != 0) begin errors++; $display("FAIL illegal%0d_reads got %0d want 0", k, rd_q.size()); end
      checks++; if (busy_seen) begin errors++; $display("FAIL illegal%0d_busy got 1 want 0", k); end
    end
  endtask

  task automatic test_reset_mid_run();
    bit to;
    clear_gen++;
    cfg_w = 8'd4; cfg_h = 8'd3; cfg_c = 8'd2; cfg_base = 16'h0100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, mem_cen} !== 3'b001) begin
      errors++; $display("FAIL rst_mid_status got %b want 001", {out_valid, busy, mem_cen});
    end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h want 00", out_data); end
    @(posedge clk); #1;
    run_frame(3, 4, 1, 16'h0040, 1'b0, -1, to);
    build_exp(3, 4, 1, 16'h0040);
    checks++; if (to) begin errors++; $display("FAIL rst_mid_timeout got no done want done"); end
    checks++; if (rd_q[0] !== 16'h0040) begin errors++; $display("FAIL rst_mid_first_addr got %h want 0040", rd_q[0]); end
    checks++; if (out_q.size() != 18) begin errors++; $display("FAIL rst_mid_words got %0d want 18", out_q.size()); end
    for (int i = 0; i < 18 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_word[i]) begin errors++; $display("FAIL rst_mid_word[%0d] got %h want %h", i, out_q[i], exp_word[i]); end
    end
  endtask

  task automatic test_start_during_run();
    bit to;
    run_frame(4, 3, 2, 16'h0100, 1'b0, 10, to);
    build_exp(4, 3, 2, 16'h0100);
    checks++; if (to) begin errors++; $display("FAIL midstart_timeout got no done want done"); end
    checks++; if (rd_q.size() != 36) begin errors++; $display("FAIL midstart_reads got %0d want 36", rd_q.size()); end
    for (int i = 0; i < 36 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_word[i]) begin errors++; $display("FAIL midstart_word[%0d] got %h want %h", i, out_q[i], exp_word[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL midstart_done_cnt got %0d want 1", done_cnt); end
    checks++; if (done_cyc != start_cyc + 39) begin errors++; $display("FAIL midstart_done_lat got %0d want 39", done_cyc - start_cyc); end
  endtask

  initial begin
    test_reset();
    test_basic_3x3();
    test_multi_channel();
    test_backpressure();
    test_illegal();
    test_reset_mid_run();
    test_start_during_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
